// File: rtl/bit_stuffer.sv
// USB bit-stuff stage. Inserts a 0 after STUFF_LEN consecutive 1s and stalls the CRC stage while it emits that bit.
// Ports: clock/reset, in_bit/in_valid/in_last -> bs_ready; out_bit/out_valid/out_last <- out_ready; pkt_done.
// Optional BIT_STUFFER_STATS_EN adds the stuff_count port.
module bit_stuffer #(
  parameter int STUFF_LEN = 6,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             bs_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             pkt_done
`ifdef BIT_STUFFER_STATS_EN
  ,
  output logic [CNT_W-1:0] stuff_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    STUFF
  } state_t;

  localparam logic [2:0] STUFF_N = 3'(STUFF_LEN);

  if (STUFF_LEN < 2 || STUFF_LEN > 7 || CNT_W < 1) begin : g_bad_param
    $error("bit_stuffer: illegal STUFF_LEN or CNT_W");
  end

  state_t     state_q, state_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic       last_pend_q, last_pend_d;
  logic       out_bit_q, out_bit_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       pkt_done_q, pkt_done_d;
`ifdef BIT_STUFFER_STATS_EN
  logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;
`endif

  logic       adv;
  logic       acc;
  logic [2:0] ones_inc;
  logic       need_stuff;

  always_comb begin
    adv        = out_ready | ~out_valid_q;
    bs_ready   = ~reset & adv & (state_q != STUFF);
    acc        = in_valid & bs_ready;
    ones_inc   = in_bit ? ones_cnt_q + 3'd1 : 3'd0;
    need_stuff = in_bit & (ones_inc == STUFF_N);

    state_d     = state_q;
    ones_cnt_d  = ones_cnt_q;
    last_pend_d = last_pend_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pkt_done_d  = out_valid_q & out_last_q & out_ready;
`ifdef BIT_STUFFER_STATS_EN
    stuff_cnt_d = stuff_cnt_q;
`endif

    // Output slot drains whenever it may advance; a load below refills it.
    if (adv) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (state_q == STUFF) begin
      if (adv) begin
        out_bit_d   = 1'b0;
        out_valid_d = 1'b1;
        out_last_d  = last_pend_q;
        ones_cnt_d  = 3'd0;
        last_pend_d = 1'b0;
        state_d     = last_pend_q ? IDLE : XFER;
`ifdef BIT_STUFFER_STATS_EN
        if (stuff_cnt_q != '1)
          stuff_cnt_d = stuff_cnt_q + 1'b1;
`endif
      end
    end else if (acc) begin
      out_bit_d   = in_bit;
      out_valid_d = 1'b1;
      // When a stuff follows, the trailing 0 carries the packet end.
      out_last_d  = in_last & ~need_stuff;
`ifdef BIT_STUFFER_STATS_EN
      if (state_q == IDLE)
        stuff_cnt_d = '0;
`endif
      if (need_stuff) begin
        state_d     = STUFF;
        last_pend_d = in_last;
        ones_cnt_d  = ones_inc;
      end else if (in_last) begin
        state_d    = IDLE;
        ones_cnt_d = 3'd0;
      end else begin
        state_d    = XFER;
        ones_cnt_d = ones_inc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ones_cnt_q  <= 3'd0;
      last_pend_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
`ifdef BIT_STUFFER_STATS_EN
      stuff_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ones_cnt_q  <= ones_cnt_d;
      last_pend_q <= last_pend_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pkt_done_q  <= pkt_done_d;
`ifdef BIT_STUFFER_STATS_EN
      stuff_cnt_q <= stuff_cnt_d;
`endif
    end
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign pkt_done  = pkt_done_q;
`ifdef BIT_STUFFER_STATS_EN
  assign stuff_count = stuff_cnt_q;
`endif

endmodule

// File: tb/tb_bit_stuffer.sv
// Testbench for bit_stuffer: directed packets with a reference stuffing model
// feeding an expected-output queue checked against the NRZI-side transfers.
module tb_bit_stuffer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic bs_ready, out_bit, out_valid, out_last, pkt_done;
`ifdef BIT_STUFFER_STATS_EN
  logic [7:0] stuff_count;
`endif

  bit_stuffer #(.STUFF_LEN(6), .CNT_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .in_bit(in_bit),
    .in_valid(in_valid),
    .in_last(in_last),
    .bs_ready(bs_ready),
    .out_bit(out_bit),
    .out_valid(out_valid),
    .out_last(out_last),
    .out_ready(out_ready),
    .pkt_done(pkt_done)
`ifdef BIT_STUFFER_STATS_EN
    ,
    .stuff_count(stuff_count)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] sb[$];
  int run = 0;
  logic pend_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a 0 follows every sixth consecutive 1; the stuffed 0
  // takes over the end-of-packet mark.
  task automatic model_push(input logic b, input logic l);
    run = b ? run + 1 : 0;
    if (run == 6) begin
      sb.push_back({b, 1'b0});
      sb.push_back({1'b0, l});
      run = 0;
    end else begin
      sb.push_back({b, l});
    end
    if (l) run = 0;
  endtask

  task automatic send_bit(input logic b, input logic l, output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    in_bit = b;
    in_last = l;
    in_valid = 1'b1;
    model_push(b, l);
    while (!acc && stalls < 50) begin
      @(negedge clock);
      acc = bs_ready;
      if (!acc) stalls++;
      @(posedge clock);
      #1;
    end
    check("accept", acc, 1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] v, input int n,
                           input logic use_last, output int total,
                           output int stall_at);
    int s;
    logic [31:0] w;
    w = v;
    total = 0;
    stall_at = -1;
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(w[i], use_last && (i == 0), s);
      if (s != 0 && stall_at < 0) stall_at = n - 1 - i;
      total += s;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clock);
    check("drain", sb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    logic [1:0] e;
    if (reset) begin
      pend_done = 1'b0;
    end else begin
      check("pkt_done", pkt_done, pend_done);
      if (out_valid && out_ready) begin
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_bit", out_bit, e[1]);
          check("out_last", out_last, e[0]);
        end
      end
      pend_done = out_valid & out_ready & out_last;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int tot, at, s;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_bs_ready", bs_ready, 0);
`ifdef BIT_STUFFER_STATS_EN
    check("rst_stuff_count", stuff_count, 0);
`endif
    reset = 1'b0;
    #1;
    check("bs_ready_idle", bs_ready, 1);
    @(posedge clock);
    #1;

    // 1: seven 1s then 0 (last)
    send_word(32'b1111_1110, 8, 1'b1, tot, at);
    check("t1_stall_total", tot, 1);
    check("t1_stall_at", at, 6);
    drain();

    // 2 then 3 back to back
    send_word(32'b11_1111, 6, 1'b1, tot, at);
    check("t2_stall_total", tot, 0);
    send_word(32'b1_1111_0111_1111, 13, 1'b1, tot, at);
    check("t3_stall_total", tot, 2);
    check("t3_stall_at", at, 0);
    drain();

    // 4: NRZI stalls for 3 cycles mid-packet
    send_word(32'b101, 3, 1'b0, tot, at);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("t4_bs_ready", bs_ready, 0);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_bit", out_bit, 1);
      check("t4_hold_last", out_last, 0);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    send_word(32'b11_1110, 6, 1'b1, tot, at);
    check("t4_stall_total", tot, 1);
    drain();

    // 5: reset while a stuff is pending
    send_word(32'b11_1111, 6, 1'b0, tot, at);
    reset = 1'b1;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_bs_ready", bs_ready, 0);
    sb.delete();
    run = 0;
    @(posedge clock);
    #1;
    check("t5_edge_valid", out_valid, 0);
    check("t5_edge_last", out_last, 0);
    reset = 1'b0;
    send_word(32'b11_1110, 6, 1'b1, tot, at);
    check("t5_no_stuff", tot, 0);
    drain();

    // 6: twelve 1s then 0 -> two stuffs; counter clears on next packet
    send_word(32'b1_1111_1111_1110, 13, 1'b1, tot, at);
    check("t6_stall_total", tot, 2);
    drain();
`ifdef BIT_STUFFER_STATS_EN
    check("t6_count", stuff_count, 2);
`endif
    send_bit(1'b0, 1'b0, s);
`ifdef BIT_STUFFER_STATS_EN
    check("t6_count_clear", stuff_count, 0);
`endif
    send_bit(1'b1, 1'b1, s);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
